// File: rtl/prism_cfg_loader_if.sv
// prism_cfg_loader_if
//   Bus bundle between the configuration loader, the host word FIFO and the
//   PRISM debug port.
//   Host push : wr_valid, wr_data (into loader), wr_ready (out of loader)
//   Debug port: dbg_addr, dbg_wr, dbg_wdata (out of loader),
//               dbg_rdata (into loader, combinational from dbg_addr)
//   Modports  : slave  = the loader itself
//               master = host / PRISM side
interface prism_cfg_loader_if;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic [5:0]  dbg_addr;
  logic        dbg_wr;
  logic [31:0] dbg_wdata;
  logic [31:0] dbg_rdata;

  modport slave (
    input  wr_valid, wr_data, dbg_rdata,
    output wr_ready, dbg_addr, dbg_wr, dbg_wdata
  );

  modport master (
    output wr_valid, wr_data, dbg_rdata,
    input  wr_ready, dbg_addr, dbg_wr, dbg_wdata
  );
endinterface

// File: rtl/prism_cfg_loader.sv
// prism_cfg_loader
//   Configuration sequencer for the PRISM state-machine core. Buffers host
//   words in a small FIFO, then holds the core in reset, writes each word to
//   consecutive debug addresses (step 4, modulo 64), optionally reads each
//   word back, and finally releases the FSM.
//
//   Optional feature: define PRISM_CFG_VERIFY_EN to add a readback VERIFY
//   cycle after every write; a readback mismatch raises error.
//
//   Ports
//     clk, rst           clock, asynchronous active-high reset
//     start              load request pulse (sampled in IDLE only)
//     abort              level, forces IDLE and flushes the FIFO
//     base_addr[5:0]     first debug byte address (latched on start)
//     word_count[4:0]    words to load, 1..16 (latched on start)
//     bus                prism_cfg_loader_if.slave: host push + debug port
//     busy               not IDLE
//     done               one-cycle pulse on successful completion
//     error              sticky, cleared by the next accepted start
//     fsm_reset          PRISM debug_reset
//     fsm_enable         PRISM fsm_enable
module prism_cfg_loader #(
  parameter int FIFO_DEPTH   = 4,    // power of two, 2..16
  parameter int RESET_CYCLES = 4,    // 1..15
  parameter int STALL_MAX    = 255   // >= 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [5:0]               base_addr,
  input  logic [4:0]               word_count,
  prism_cfg_loader_if.slave        bus,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic                     fsm_reset,
  output logic                     fsm_enable
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STALL_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_WRITE,
    S_VERIFY,
    S_ENABLE
  } state_t;

  state_t        state;
  logic [3:0]    rst_cnt;
  logic [4:0]    remaining;   // words not yet issued
  logic [5:0]    cur_addr;
  logic [SW-1:0] stall_cnt;

  // ---------------------------------------------------------------------
  // Word FIFO
  // ---------------------------------------------------------------------
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  logic          issue;       // pop the head and drive it as next cycle's write
  logic          flush;
  logic          issue_slot;
  logic          stall_hit;

  assign full         = (count == CW'(FIFO_DEPTH));
  assign empty        = (count == '0);
  assign bus.wr_ready = !full;
  assign push         = bus.wr_valid && !full && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + AW'(1);
      if (issue) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(issue);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.wr_data;
  end

`ifdef PRISM_CFG_VERIFY_EN
  logic mismatch;
  // dbg_wdata still holds the word written in the preceding WRITE cycle
  assign mismatch = (bus.dbg_rdata != bus.dbg_wdata);
`else
  logic unused_rdata;
  assign unused_rdata = ^bus.dbg_rdata;
`endif

  // ---------------------------------------------------------------------
  // Write slot decision. dbg_wr is registered, so the choice to write in the
  // next cycle (and the matching FIFO pop) is made at the end of the cycle
  // before it: the last RESET cycle, a WRITE cycle, or a passing VERIFY.
  // ---------------------------------------------------------------------
  assign stall_hit = (stall_cnt == SW'(STALL_MAX - 1));

  always_comb begin
    issue_slot = 1'b0;
    flush      = 1'b0;
    if (abort) begin
      flush = 1'b1;
    end else begin
      case (state)
        S_RESET: issue_slot = (rst_cnt == '0);
        S_WRITE: begin
          if (bus.dbg_wr) begin
`ifdef PRISM_CFG_VERIFY_EN
            issue_slot = 1'b0;
`else
            issue_slot = (remaining != '0);
`endif
          end else if (stall_hit) begin
            flush = 1'b1;
          end else begin
            issue_slot = 1'b1;
          end
        end
`ifdef PRISM_CFG_VERIFY_EN
        S_VERIFY: begin
          if (mismatch) flush = 1'b1;
          else          issue_slot = (remaining != '0);
        end
`endif
        default: ;
      endcase
    end
  end

  assign issue = issue_slot && !empty;

  // ---------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      fsm_reset     <= 1'b0;
      fsm_enable    <= 1'b0;
      bus.dbg_wr    <= 1'b0;
      bus.dbg_addr  <= '0;
      bus.dbg_wdata <= '0;
      cur_addr      <= '0;
      remaining     <= '0;
      rst_cnt       <= '0;
      stall_cnt     <= '0;
    end else begin
      done       <= 1'b0;
      bus.dbg_wr <= 1'b0;

      if (abort) begin
        state      <= S_IDLE;
        busy       <= 1'b0;
        fsm_reset  <= 1'b0;
        fsm_enable <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              if (word_count != 5'd0 && word_count <= 5'd16) begin
                state      <= S_RESET;
                busy       <= 1'b1;
                error      <= 1'b0;
                fsm_reset  <= 1'b1;
                fsm_enable <= 1'b0;
                cur_addr   <= base_addr;
                remaining  <= word_count;
                rst_cnt    <= 4'(RESET_CYCLES - 1);
                stall_cnt  <= '0;
              end else begin
                error <= 1'b1;
              end
            end
          end

          S_RESET: begin
            if (rst_cnt == '0) state <= S_WRITE;
            else               rst_cnt <= rst_cnt - 4'd1;
          end

          S_WRITE: begin
            if (bus.dbg_wr) begin
`ifdef PRISM_CFG_VERIFY_EN
              state <= S_VERIFY;
`else
              if (remaining == '0) begin
                state      <= S_ENABLE;
                fsm_reset  <= 1'b0;
                fsm_enable <= 1'b1;
                done       <= 1'b1;
              end
`endif
            end else if (stall_hit) begin
              state     <= S_IDLE;
              busy      <= 1'b0;
              error     <= 1'b1;
              fsm_reset <= 1'b0;
            end else begin
              stall_cnt <= stall_cnt + SW'(1);
            end
          end

`ifdef PRISM_CFG_VERIFY_EN
          S_VERIFY: begin
            if (mismatch) begin
              state     <= S_IDLE;
              busy      <= 1'b0;
              error     <= 1'b1;
              fsm_reset <= 1'b0;
            end else if (remaining == '0) begin
              state      <= S_ENABLE;
              fsm_reset  <= 1'b0;
              fsm_enable <= 1'b1;
              done       <= 1'b1;
            end else begin
              state <= S_WRITE;
            end
          end
`endif

          S_ENABLE: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end

          default: begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            fsm_reset <= 1'b0;
          end
        endcase
      end

      // Placed last so a successful issue overrides the stall increment above
      if (issue) begin
        bus.dbg_wr    <= 1'b1;
        bus.dbg_addr  <= cur_addr;
        bus.dbg_wdata <= mem[rd_ptr];
        cur_addr      <= cur_addr + 6'd4;
        remaining     <= remaining - 5'd1;
        stall_cnt     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_prism_cfg_loader.sv
// tb_prism_cfg_loader
//   Directed bench for prism_cfg_loader with hand-computed expectations.
//   A small debug-memory model answers dbg_rdata; it can corrupt readback.
module tb_prism_cfg_loader;

  localparam int DEPTH   = 4;
  localparam int RST_CYC = 4;
  localparam int STALL   = 255;
`ifdef PRISM_CFG_VERIFY_EN
  localparam int VFY = 1;
`else
  localparam int VFY = 0;
`endif

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic [5:0] base_addr;
  logic [4:0] word_count;
  logic       busy;
  logic       done;
  logic       error;
  logic       fsm_reset;
  logic       fsm_enable;
  logic       corrupt;

  int n_checks;
  int n_errors;

  logic [31:0] dmem [64];

  prism_cfg_loader_if ifc ();

  prism_cfg_loader #(
    .FIFO_DEPTH  (DEPTH),
    .RESET_CYCLES(RST_CYC),
    .STALL_MAX   (STALL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .base_addr  (base_addr),
    .word_count (word_count),
    .bus        (ifc.slave),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .fsm_reset  (fsm_reset),
    .fsm_enable (fsm_enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Debug memory model: captures writes, returns (optionally corrupted) data
  always @(posedge clk) begin
    if (ifc.dbg_wr) dmem[ifc.dbg_addr] <= ifc.dbg_wdata;
  end
  assign ifc.dbg_rdata = dmem[ifc.dbg_addr] ^ {31'b0, corrupt};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    ifc.wr_valid = 1'b1;
    ifc.wr_data  = d;
    tick();
    ifc.wr_valid = 1'b0;
  endtask

  task automatic wait_wr(input int bound);
    int k;
    k = 0;
    while (!ifc.dbg_wr && k < bound) begin
      tick();
      k++;
    end
    check("wr_seen", ifc.dbg_wr, 1);
  endtask

  // Fill an (expected empty) FIFO, check full flag and refused extra push,
  // then abort to leave it empty again.
  task automatic check_capacity();
    for (int i = 0; i < DEPTH; i++) begin
      check("cap_rdy", ifc.wr_ready, 1);
      push(32'hC0DE_0000 + 32'(i));
    end
    check("cap_full", ifc.wr_ready, 0);
    push(32'hDEAD_BEEF);
    check("cap_still_full", ifc.wr_ready, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("cap_flushed", ifc.wr_ready, 1);
  endtask

  // Full successful load; optionally pushes at the FIFO pop edges of the
  // first push_n words (push_base + j).
  task automatic do_load(input logic [5:0] base, input int n, input logic [31:0] w [16],
                         input int push_n, input logic [31:0] push_base);
    logic [5:0] a;
    a          = base;
    base_addr  = base;
    word_count = 5'(n);
    start      = 1'b1;
    tick();
    start      = 1'b0;
    check("ld_err_clr", error, 0);
    for (int i = 0; i < RST_CYC; i++) begin
      if (i > 0) tick();
      check("rst_hold", fsm_reset, 1);
      check("rst_nowr", ifc.dbg_wr, 0);
      check("rst_en", fsm_enable, 0);
      check("rst_busy", busy, 1);
    end
    for (int j = 0; j < n; j++) begin
      ifc.wr_valid = (j < push_n);
      ifc.wr_data  = push_base + 32'(j);
      tick();
      ifc.wr_valid = 1'b0;
      check("wr_strobe", ifc.dbg_wr, 1);
      check("wr_addr", {26'b0, ifc.dbg_addr}, {26'b0, a});
      check("wr_data", ifc.dbg_wdata, w[j]);
`ifdef PRISM_CFG_VERIFY_EN
      tick();
      check("vfy_nowr", ifc.dbg_wr, 0);
      check("vfy_addr", {26'b0, ifc.dbg_addr}, {26'b0, a});
`endif
      a = a + 6'd4;
    end
    tick();
    check("done_pulse", done, 1);
    check("en_on", fsm_enable, 1);
    check("en_rst_off", fsm_reset, 0);
    tick();
    check("idle_busy", busy, 0);
    check("done_clr", done, 0);
    check("en_held", fsm_enable, 1);
    check("no_err", error, 0);
  endtask

  initial begin
    logic [31:0] w [16];
    int          n;

    n_checks     = 0;
    n_errors     = 0;
    rst          = 1'b1;
    start        = 1'b0;
    abort        = 1'b0;
    corrupt      = 1'b0;
    base_addr    = '0;
    word_count   = '0;
    ifc.wr_valid = 1'b0;
    ifc.wr_data  = '0;
    for (int i = 0; i < 64; i++) dmem[i] = '0;
    for (int i = 0; i < 16; i++) w[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_fsm_reset", fsm_reset, 0);
    check("rst_fsm_enable", fsm_enable, 0);
    check("rst_dbg_wr", ifc.dbg_wr, 0);
    check("rst_dbg_addr", {26'b0, ifc.dbg_addr}, 0);
    check("rst_dbg_wdata", ifc.dbg_wdata, 0);
    check("rst_wr_ready", ifc.wr_ready, 1);

    // Basic 3-word load from base 0x08
    push(32'h1111_1111);
    push(32'h2222_2222);
    push(32'h3333_3333);
    w[0] = 32'h1111_1111; w[1] = 32'h2222_2222; w[2] = 32'h3333_3333;
    do_load(6'h08, 3, w, 0, 32'h0);

    // Address wrap 0x3C -> 0x00
    push(32'hAAAA_0001);
    push(32'hAAAA_0002);
    w[0] = 32'hAAAA_0001; w[1] = 32'hAAAA_0002;
    do_load(6'h3C, 2, w, 0, 32'h0);

    // Invalid word counts
    word_count = 5'd0;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    check("cnt0_err", error, 1);
    check("cnt0_busy", busy, 0);
    check("cnt0_nowr", ifc.dbg_wr, 0);
    check("cnt0_en_held", fsm_enable, 1);
    repeat (3) begin
      tick();
      check("cnt0_idle", busy, 0);
      check("cnt0_nowr2", ifc.dbg_wr, 0);
    end
    word_count = 5'd17;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    check("cnt17_err", error, 1);
    check("cnt17_busy", busy, 0);

    // Valid start clears error; one word is left over in the FIFO
    push(32'h0000_000A);
    push(32'h0000_000B);
    w[0] = 32'h0000_000A;
    do_load(6'h20, 1, w, 0, 32'h0);

    // Abort in IDLE drops fsm_enable and flushes the leftover word
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abi_en", fsm_enable, 0);
    check("abi_busy", busy, 0);
    check("abi_err", error, 0);
    check_capacity();

    // Push and pop on the same edge keep the FIFO level constant
    push(32'hC000_0000);
    push(32'hC000_0001);
    push(32'hC000_0002);
    w[0] = 32'hC000_0000; w[1] = 32'hC000_0001;
    do_load(6'h10, 2, w, 2, 32'hD000_0000);
    check("pp_rdy", ifc.wr_ready, 1);
    push(32'hE000_0000);
    check("pp_full", ifc.wr_ready, 0);
    // Push refused while full even though a pop happens on that edge
    w[0] = 32'hC000_0002; w[1] = 32'hD000_0000; w[2] = 32'hD000_0001; w[3] = 32'hE000_0000;
    do_load(6'h00, 4, w, 1, 32'hF000_0000);
    check_capacity();

    // Stall timeout: 4 words requested, only 1 supplied
    push(32'h5555_0000);
    base_addr  = 6'h00;
    word_count = 5'd4;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    wait_wr(20);
    n = 0;
    for (int k = 0; k < 600; k++) begin
      tick();
      if (!busy) break;
      if (!ifc.dbg_wr) n++;
    end
    check("stall_busy", busy, 0);
    check("stall_cycles", 32'(n), 32'(STALL + VFY));
    check("stall_err", error, 1);
    check("stall_fsm_reset", fsm_reset, 0);
    check("stall_fsm_enable", fsm_enable, 0);
    check("stall_rdy", ifc.wr_ready, 1);

    // Abort mid-WRITE, with a simultaneous push that must be refused
    push(32'h6666_0000);
    word_count = 5'd3;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    wait_wr(20);
    tick();
`ifdef PRISM_CFG_VERIFY_EN
    tick();
`endif
    check("abw_busy_pre", busy, 1);
    check("abw_rst_pre", fsm_reset, 1);
    abort        = 1'b1;
    ifc.wr_valid = 1'b1;
    ifc.wr_data  = 32'h7777_7777;
    tick();
    abort        = 1'b0;
    ifc.wr_valid = 1'b0;
    check("abw_busy", busy, 0);
    check("abw_fsm_reset", fsm_reset, 0);
    check("abw_fsm_enable", fsm_enable, 0);
    check("abw_rdy", ifc.wr_ready, 1);
    check("abw_err", error, 0);
    check("abw_nowr", ifc.dbg_wr, 0);
    check_capacity();

`ifdef PRISM_CFG_VERIFY_EN
    // Readback mismatch on the second word
    push(32'h9000_0000);
    push(32'h9000_0001);
    push(32'h9000_0002);
    base_addr  = 6'h04;
    word_count = 5'd3;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    repeat (RST_CYC - 1) tick();
    tick();
    check("mm_wr0", ifc.dbg_wdata, 32'h9000_0000);
    tick();
    tick();
    check("mm_wr1_addr", {26'b0, ifc.dbg_addr}, 32'h08);
    check("mm_wr1_data", ifc.dbg_wdata, 32'h9000_0001);
    corrupt = 1'b1;
    tick();
    check("mm_vfy_nowr", ifc.dbg_wr, 0);
    tick();
    corrupt = 1'b0;
    check("mm_err", error, 1);
    check("mm_busy", busy, 0);
    check("mm_fsm_reset", fsm_reset, 0);
    check("mm_fsm_enable", fsm_enable, 0);
    check("mm_done", done, 0);
    check_capacity();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
